// File: rtl/sram_capture_ctrl_pkg.sv
// sram_capture_ctrl_pkg: state codes, trigger-source codes and default widths for the snapshot sequencer.
package sram_capture_ctrl_pkg;
  localparam int N_ADDR_DEF = 10;
  localparam int N_HOLD_DEF = 16;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_HOLD  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } capture_state_t;
  localparam logic [1:0] SEL_EXT    = 2'd0;
  localparam logic [1:0] SEL_JTAG   = 2'd1;
  localparam logic [1:0] SEL_EITHER = 2'd2;
  localparam logic [1:0] SEL_AUTO   = 2'd3;
endpackage

// File: rtl/sram_capture_ctrl_trig_edge_sync.sv
// trig_edge_sync: optional 2-flop synchronizer followed by a rising-edge detector.
module trig_edge_sync #(
  parameter bit SYNC = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic lvl;
  logic prev;
  if (SYNC) begin : g_sync
    logic [1:0] sff;
    always_ff @(posedge clk or posedge rst)
      if (rst) sff <= '0;
      else sff <= {sff[0], din};
    assign lvl = sff[1];
  end else begin : g_direct
    assign lvl = din;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) prev <= 1'b0;
    else prev <= lvl;
  assign rise = lvl & ~prev;
endmodule

// File: rtl/sram_capture_ctrl.sv
// sram_capture_ctrl: arm/trigger/holdoff sequencer emitting one contiguous SRAM write burst per capture.
// Define SRAM_CAPTURE_DECIM_EN to add the dec_ratio input for decimated writes.
module sram_capture_ctrl
  import sram_capture_ctrl_pkg::*;
#(
  parameter int N_ADDR = N_ADDR_DEF,
  parameter int N_HOLD = N_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_ext,
  input  logic              trig_jtag,
  input  logic [1:0]        trig_sel,
  input  logic [N_HOLD-1:0] holdoff,
  input  logic [N_ADDR-1:0] wr_len,
`ifdef SRAM_CAPTURE_DECIM_EN
  input  logic [3:0]        dec_ratio,
`endif
  output logic              wr_en,
  output logic [N_ADDR-1:0] wr_addr,
  output logic [2:0]        state,
  output logic              done,
  output logic [7:0]        trig_count
);
  capture_state_t    cs;
  logic              ext_e, jtag_e, arm_e, arm_go, qual, accept;
  logic [1:0]        sel_q;
  logic [N_HOLD-1:0] hold_q, cnt;
  logic [N_ADDR-1:0] len_q;
  logic [3:0]        dec_in, dec_q, gap;
`ifdef SRAM_CAPTURE_DECIM_EN
  assign dec_in = dec_ratio;
`else
  assign dec_in = 4'd0;
`endif
  trig_edge_sync #(.SYNC(1'b1)) u_ext  (.clk(clk), .rst(rst), .din(trig_ext),  .rise(ext_e));
  trig_edge_sync #(.SYNC(1'b0)) u_jtag (.clk(clk), .rst(rst), .din(trig_jtag), .rise(jtag_e));
  trig_edge_sync #(.SYNC(1'b0)) u_arm  (.clk(clk), .rst(rst), .din(arm),       .rise(arm_e));
  assign state  = cs;
  assign arm_go = arm_e && (cs == S_IDLE || cs == S_DONE);
  assign qual   = cs == S_ARMED && (sel_q == SEL_EXT ? ext_e :
                                    sel_q == SEL_JTAG ? jtag_e :
                                    sel_q == SEL_EITHER && (ext_e || jtag_e));
  // in auto mode the arm edge itself is the accepted trigger
  assign accept = qual || (arm_go && trig_sel == SEL_AUTO);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cs         <= S_IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      done       <= 1'b0;
      trig_count <= '0;
      sel_q      <= '0;
      hold_q     <= '0;
      len_q      <= '0;
      dec_q      <= '0;
      cnt        <= '0;
      gap        <= '0;
    end else if (abort) begin
      cs      <= S_IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      done    <= 1'b0;
    end else if (accept) begin
      trig_count <= trig_count + 8'(trig_count != 8'hff);
      hold_q     <= holdoff;
      len_q      <= wr_len;
      dec_q      <= dec_in;
      done       <= 1'b0;
      wr_addr    <= '0;
      cnt        <= N_HOLD'(1);
      cs         <= holdoff == '0 ? S_WRITE : S_HOLD;
      wr_en      <= holdoff == '0;
    end else if (arm_go) begin
      cs    <= S_ARMED;
      sel_q <= trig_sel;
      done  <= 1'b0;
    end else if (cs == S_HOLD) begin
      cnt <= cnt + N_HOLD'(1);
      if (cnt == hold_q) begin
        cs    <= S_WRITE;
        wr_en <= 1'b1;
      end
    end else if (cs == S_WRITE) begin
      // gap counts the idle cycles left before the next decimated write
      if (!wr_en) begin
        gap   <= gap - 4'd1;
        wr_en <= gap == 4'd1;
      end else if (wr_addr == len_q) begin
        cs    <= S_DONE;
        wr_en <= 1'b0;
        done  <= 1'b1;
      end else begin
        wr_addr <= wr_addr + N_ADDR'(1);
        gap     <= dec_q;
        wr_en   <= dec_q == 4'd0;
      end
    end
endmodule

// File: tb/tb_sram_capture_ctrl.sv
// tb_sram_capture_ctrl: directed and randomized checks of the capture sequencer against a cycle-arithmetic model.
module tb_sram_capture_ctrl;
  localparam int NA = 10;
  localparam int NH = 16;
  logic          clk = 1'b0, rst = 1'b1, arm = 1'b0, abort = 1'b0, trig_ext = 1'b0, trig_jtag = 1'b0;
  logic [1:0]    trig_sel = 2'd0;
  logic [NH-1:0] holdoff = '0;
  logic [NA-1:0] wr_len = '0;
  logic [3:0]    dec = 4'd0;
  logic          wr_en, done;
  logic [NA-1:0] wr_addr;
  logic [2:0]    state;
  logic [7:0]    trig_count;
  int errors = 0, checks = 0;
  int m_mode, m_t0, m_h, m_len, m_d, m_addr, m_cnt, m_sel, ncyc;
  bit e1, e2, e3, jp, ap;

  always #5 clk = ~clk;

  sram_capture_ctrl #(.N_ADDR(NA), .N_HOLD(NH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_ext(trig_ext), .trig_jtag(trig_jtag),
    .trig_sel(trig_sel), .holdoff(holdoff), .wr_len(wr_len),
`ifdef SRAM_CAPTURE_DECIM_EN
    .dec_ratio(dec),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .state(state), .done(done), .trig_count(trig_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // model: mode 0 idle, 1 armed, 2 capturing (hold+write by cycle arithmetic), 3 done
  task m_accept();
    m_cnt  = m_cnt < 255 ? m_cnt + 1 : 255;
    m_t0   = ncyc;
    m_h    = int'(holdoff);
    m_len  = int'(wr_len);
`ifdef SRAM_CAPTURE_DECIM_EN
    m_d    = int'(dec);
`else
    m_d    = 0;
`endif
    m_addr = 0;
    m_mode = 2;
  endtask

  initial begin : model
    int k, es, en, ea, ed, ec;
    bit ee, je, ae;
    ncyc = 0;
    forever begin
      @(posedge clk);
      ncyc++;
      if (rst) begin
        m_mode = 0; m_addr = 0; m_cnt = 0;
        e1 = 0; e2 = 0; e3 = 0; jp = 0; ap = 0;
      end else begin
        ee = e2 && !e3;
        je = trig_jtag && !jp;
        ae = arm && !ap;
        e3 = e2; e2 = e1; e1 = trig_ext; jp = trig_jtag; ap = arm;
        if (abort) begin
          m_mode = 0; m_addr = 0;
        end else if ((m_mode == 0 || m_mode == 3) && ae && trig_sel == 2'd3) m_accept();
        else if ((m_mode == 0 || m_mode == 3) && ae) begin
          m_mode = 1; m_sel = int'(trig_sel);
        end else if (m_mode == 1 && (m_sel == 0 ? ee : m_sel == 1 ? je : m_sel == 2 && (ee || je))) m_accept();
        if (m_mode == 2 && ncyc - m_t0 - m_h > m_len * (m_d + 1)) begin
          m_mode = 3; m_addr = m_len;
        end
      end
      @(negedge clk);
      es = 0; en = 0; ea = m_addr; ed = 0; ec = m_cnt;
      if (rst) begin
        ea = 0; ec = 0;
      end else if (m_mode == 1) es = 1;
      else if (m_mode == 3) begin
        es = 4; ed = 1;
      end else if (m_mode == 2) begin
        k = ncyc - m_t0 - m_h;
        es = k < 0 ? 2 : 3;
        en = int'(k >= 0 && k % (m_d + 1) == 0);
        ea = k < 0 ? 0 : (k + m_d) / (m_d + 1);
      end
      chk("state", int'(state), es);
      chk("wr_en", int'(wr_en), en);
      chk("wr_addr", int'(wr_addr), ea);
      chk("done", int'(done), ed);
      chk("trig_count", int'(trig_count), ec);
    end
  end

  task automatic wait_wr(output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (wr_en) return;
      if (lat > 5000) begin
        timeout("wait_wr");
        return;
      end
    end
  endtask

  task automatic run_until_done(output int nw);
    nw = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) return;
      nw += int'(wr_en);
    end
    timeout("run_until_done");
  endtask

  task automatic arm_pulse(input logic [1:0] sel, input int h, input int len);
    @(negedge clk);
    trig_sel = sel; holdoff = NH'(h); wr_len = NA'(len); arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  initial begin : stim
    int lat, l2, nw;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_trig_count", int'(trig_count), 0);
    rst = 1'b0;
    // jtag trigger, no holdoff, 8 words
    arm_pulse(2'd1, 0, 7);
    chk("armed_state", int'(state), 1);
    trig_jtag = 1'b1;
    wait_wr(lat);
    chk("jtag_latency", lat, 1);
    run_until_done(nw);
    trig_jtag = 1'b0;
    chk("burst8_len", nw, 8);
    chk("burst8_state", int'(state), 4);
    chk("burst8_count", int'(trig_count), 1);
    chk("burst8_last_addr", int'(wr_addr), 7);
    // external trigger through the synchronizer, holdoff 5
    arm_pulse(2'd0, 5, 3);
    trig_ext = 1'b1;
    l2 = 0; lat = 0;
    while (!wr_en && lat < 100) begin
      @(negedge clk);
      lat++;
      if (state == 3'd2 && l2 == 0) l2 = lat;
    end
    chk("ext_accept_latency", l2, 3);
    chk("ext_first_write", lat, 8);
    run_until_done(nw);
    trig_ext = 1'b0;
    chk("burst4_len", nw, 4);
    // abort mid-burst
    arm_pulse(2'd2, 0, 20);
    trig_jtag = 1'b1;
    lat = 0;
    while (!(wr_en && wr_addr == NA'(3)) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("abort_reached_addr3", int'(wr_addr), 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; trig_jtag = 1'b0;
    chk("abort_state", int'(state), 0);
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_addr", int'(wr_addr), 0);
    chk("abort_keeps_count", int'(trig_count), 3);
    // full-depth burst, then auto re-arm restarts at address 0
    arm_pulse(2'd1, 2, 1023);
    trig_jtag = 1'b1;
    wait_wr(lat);
    run_until_done(nw);
    trig_jtag = 1'b0;
    chk("full_depth_len", nw, 1024);
    chk("full_depth_last", int'(wr_addr), 1023);
    @(negedge clk);
    trig_sel = 2'd3; holdoff = '0; wr_len = NA'(2); arm = 1'b1;
    wait_wr(lat);
    arm = 1'b0;
    chk("auto_latency", lat, 1);
    chk("rearm_addr0", int'(wr_addr), 0);
    run_until_done(nw);
    chk("auto_len", nw, 3);
    // saturate the accepted-trigger counter
    trig_sel = 2'd1; holdoff = '0; wr_len = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      arm = 1'b1; trig_jtag = 1'b0;
      @(negedge clk);
      arm = 1'b0; trig_jtag = 1'b1;
      @(negedge clk);
      trig_jtag = 1'b0;
    end
    @(negedge clk);
    chk("count_saturated", int'(trig_count), 255);
    // asynchronous reset during a write burst
    arm_pulse(2'd1, 0, 50);
    trig_jtag = 1'b1;
    wait_wr(lat);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wr_en", int'(wr_en), 0);
    chk("async_rst_count", int'(trig_count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; trig_jtag = 1'b0;
    // random traffic, compared cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) arm = ~arm;
      if ($urandom_range(0, 2) == 0) trig_jtag = ~trig_jtag;
      if ($urandom_range(0, 4) == 0) trig_ext = ~trig_ext;
      abort    = $urandom_range(0, 63) == 0;
      trig_sel = 2'($urandom_range(0, 3));
      holdoff  = NH'($urandom_range(0, 4));
      wr_len   = NA'($urandom_range(0, 11));
`ifdef SRAM_CAPTURE_DECIM_EN
      dec      = 4'($urandom_range(0, 3));
`endif
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
